// File: rtl/div_issue_ctrl.sv
// rtl/div_issue_ctrl.sv - issue controller between the EX stage and the shared 32-bit divider
module div_issue_ctrl #(
    parameter int TAG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [31:0]      req_src1,
    input  logic [31:0]      req_src2,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic [3:0]       div_op,
    output logic [31:0]      div_src1,
    output logic [31:0]      div_src2,
    input  logic             div_done,
    input  logic [31:0]      div_res,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic [TAG_W-1:0] res_tag,
    output logic             busy,
    output logic [CNT_W-1:0] done_cnt,
    output logic [7:0]       last_lat
);

    localparam logic [3:0] S_IDLE  = 4'b0001;
    localparam logic [3:0] S_BUSY  = 4'b0010;
    localparam logic [3:0] S_DONE  = 4'b0100;
    localparam logic [3:0] S_DRAIN = 4'b1000;

    logic [3:0]       state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [31:0]      src1_q, src1_d;
    logic [31:0]      src2_q, src2_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [31:0]      res_data_q, res_data_d;
    logic [CNT_W-1:0] done_cnt_q, done_cnt_d;
    logic [7:0]       lat_cnt_q, lat_cnt_d;
    logic [7:0]       last_lat_q, last_lat_d;

    logic             accept;
    logic             op_legal;
    logic [7:0]       lat_inc;

    assign accept   = req_valid & req_ready;
    assign op_legal = $onehot(req_op);
    assign lat_inc  = (lat_cnt_q == 8'hFF) ? 8'hFF : lat_cnt_q + 8'd1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A running divide cannot be aborted, so a flush without div_done parks in DRAIN
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = op_legal ? S_BUSY : S_DONE;
                end
            end
            S_BUSY: begin
                if (div_done) begin
                    state_d = flush ? S_IDLE : S_DONE;
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (div_done) begin
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (res_ready) begin
                    if (accept) begin
                        state_d = op_legal ? S_BUSY : S_DONE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        div_op    = 4'b0000;
        res_valid = 1'b0;
        busy      = (state_q != S_IDLE);
        case (state_q)
            S_IDLE:  req_ready = ~flush;
            S_BUSY:  div_op    = op_q;
            S_DRAIN: div_op    = op_q;
            S_DONE: begin
                res_valid = 1'b1;
                req_ready = res_ready & ~flush;
            end
            default: ;
        endcase
    end

    always_comb begin
        op_d       = op_q;
        src1_d     = src1_q;
        src2_d     = src2_q;
        tag_d      = tag_q;
        res_data_d = res_data_q;
        done_cnt_d = done_cnt_q;
        lat_cnt_d  = lat_cnt_q;
        last_lat_d = last_lat_q;

        if (accept) begin
            op_d      = req_op;
            src1_d    = req_src1;
            src2_d    = req_src2;
            tag_d     = req_tag;
            lat_cnt_d = 8'd0;
            if (!op_legal) begin
                res_data_d = 32'd0;
            end
        end

        // The count includes the div_done cycle itself
        if (state_q == S_BUSY) begin
            lat_cnt_d = lat_inc;
            if (div_done && !flush) begin
                res_data_d = div_res;
                last_lat_d = lat_inc;
            end
        end

        if ((state_q == S_DONE) && res_ready && !flush && (done_cnt_q != {CNT_W{1'b1}})) begin
            done_cnt_d = done_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_q       <= 4'b0000;
            src1_q     <= 32'd0;
            src2_q     <= 32'd0;
            tag_q      <= '0;
            res_data_q <= 32'd0;
            done_cnt_q <= '0;
            lat_cnt_q  <= 8'd0;
            last_lat_q <= 8'd0;
        end else begin
            op_q       <= op_d;
            src1_q     <= src1_d;
            src2_q     <= src2_d;
            tag_q      <= tag_d;
            res_data_q <= res_data_d;
            done_cnt_q <= done_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
            last_lat_q <= last_lat_d;
        end
    end

    assign div_src1 = src1_q;
    assign div_src2 = src2_q;
    assign res_data = res_data_q;
    assign res_tag  = tag_q;
    assign done_cnt = done_cnt_q;
    assign last_lat = last_lat_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb/tb_div_issue_ctrl.sv - self-checking bench for div_issue_ctrl
module tb_div_issue_ctrl;
    localparam int TAG_W = 5;
    localparam int CNT_W = 16;
    localparam int P_IDLE  = 0;
    localparam int P_RUN   = 1;
    localparam int P_HOLD  = 2;
    localparam int P_DRAIN = 3;

    logic             clk = 1'b0;
    logic             resetn;
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_op;
    logic [31:0]      req_src1;
    logic [31:0]      req_src2;
    logic [TAG_W-1:0] req_tag;
    logic             flush;
    logic [3:0]       div_op;
    logic [31:0]      div_src1;
    logic [31:0]      div_src2;
    logic             div_done;
    logic [31:0]      div_res;
    logic             res_valid;
    logic             res_ready;
    logic [31:0]      res_data;
    logic [TAG_W-1:0] res_tag;
    logic             busy;
    logic [CNT_W-1:0] done_cnt;
    logic [7:0]       last_lat;

    always #5 clk = ~clk;

    div_issue_ctrl #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_src1(req_src1), .req_src2(req_src2), .req_tag(req_tag),
        .flush(flush),
        .div_op(div_op), .div_src1(div_src1), .div_src2(div_src2),
        .div_done(div_done), .div_res(div_res),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_tag(res_tag),
        .busy(busy), .done_cnt(done_cnt), .last_lat(last_lat)
    );

    int n_pass = 0;
    int n_total = 0;

    // Reference: phase of the request, latched operands, delivered count and divider timing
    int               ph;
    int               m_cnt;
    int               m_lat;
    int               m_run;
    int               dv_cnt;
    int               dv_len;
    int               forced_len = 0;
    logic [3:0]       m_op;
    logic [31:0]      m_a;
    logic [31:0]      m_b;
    logic [31:0]      m_res;
    logic [TAG_W-1:0] m_tag;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] div_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (b == 32'd0) return ~a;
        case (op)
            4'b0001: return 32'(sa / sb);
            4'b0010: return a / b;
            4'b0100: return 32'(sa % sb);
            default: return a % b;
        endcase
    endfunction

    task automatic model_reset();
        ph = P_IDLE; m_cnt = 0; m_lat = 0; m_run = 0; dv_cnt = 0; dv_len = 1;
        m_op = 4'd0; m_a = 32'd0; m_b = 32'd0; m_res = 32'd0; m_tag = '0;
    endtask

    task automatic take();
        m_op = req_op; m_a = req_src1; m_b = req_src2; m_tag = req_tag;
        m_run = 0; dv_cnt = 0;
        dv_len = (forced_len > 0) ? forced_len : $urandom_range(1, 24);
        if ($countones(req_op) == 1) begin
            ph = P_RUN;
        end else begin
            ph = P_HOLD;
            m_res = 32'd0;
        end
    endtask

    task automatic model_next();
        logic acc;
        if (!resetn) return;
        acc = req_valid && !flush && (ph == P_IDLE || (ph == P_HOLD && res_ready));
        case (ph)
            P_IDLE: if (acc) take();
            P_RUN: begin
                if (div_done) begin
                    if (flush) begin
                        ph = P_IDLE;
                    end else begin
                        ph = P_HOLD;
                        m_res = div_fn(m_op, m_a, m_b);
                        m_lat = (m_run + 1 > 255) ? 255 : m_run + 1;
                    end
                end else if (flush) begin
                    ph = P_DRAIN;
                end else begin
                    m_run++;
                end
            end
            P_DRAIN: if (div_done) ph = P_IDLE;
            default: begin
                if (flush) begin
                    ph = P_IDLE;
                end else if (res_ready) begin
                    if (m_cnt < 65535) m_cnt++;
                    if (acc) take();
                    else ph = P_IDLE;
                end
            end
        endcase
    endtask

    // Divider: counts its active cycles and answers on the dv_len-th one; stray pulses otherwise
    task automatic drive_div();
        if (ph == P_RUN || ph == P_DRAIN) begin
            dv_cnt++;
            div_done = (dv_cnt == dv_len);
            div_res  = div_done ? div_fn(m_op, m_a, m_b) : $urandom;
        end else begin
            div_done = ($urandom_range(0, 15) == 0);
            div_res  = $urandom;
        end
    endtask

    task automatic compare();
        logic run;
        logic exp_rr;
        run    = (ph == P_RUN) || (ph == P_DRAIN);
        exp_rr = !flush && (ph == P_IDLE || (ph == P_HOLD && res_ready));
        chk("req_ready", 64'(req_ready), 64'(exp_rr));
        chk("busy", 64'(busy), 64'(ph != P_IDLE));
        chk("div_op", 64'(div_op), run ? 64'(m_op) : 64'd0);
        chk("res_valid", 64'(res_valid), 64'(ph == P_HOLD));
        chk("done_cnt", 64'(done_cnt), 64'(m_cnt));
        chk("last_lat", 64'(last_lat), 64'(m_lat));
        if (run || !resetn) begin
            chk("div_src1", 64'(div_src1), 64'(m_a));
            chk("div_src2", 64'(div_src2), 64'(m_b));
        end
        if (ph == P_HOLD || !resetn) begin
            chk("res_data", 64'(res_data), 64'(m_res));
            chk("res_tag", 64'(res_tag), 64'(m_tag));
        end
    endtask

    task automatic step();
        #3;
        if (!resetn) model_reset();
        compare();
        model_next();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tag, input logic fl, input logic rr);
        req_valid = v; req_op = op; req_src1 = a; req_src2 = b; req_tag = tag;
        flush = fl; res_ready = rr;
        drive_div();
    endtask

    task automatic cyc(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag, input logic fl, input logic rr);
        apply(v, op, a, b, tag, fl, rr);
        step();
    endtask

    task automatic idle(input logic rr);
        cyc(1'b0, 4'd0, 32'd0, 32'd0, '0, 1'b0, rr);
    endtask

    task automatic wait_res(input int budget);
        int n;
        n = 0;
        while (!res_valid && n < budget) begin
            idle(1'b0);
            n++;
        end
        chk("wait_res_timeout", 64'(res_valid), 64'd1);
    endtask

    initial begin
        int n;
        model_reset();
        resetn = 1'b0;
        req_valid = 1'b0; req_op = 4'd0; req_src1 = 32'd0; req_src2 = 32'd0; req_tag = '0;
        flush = 1'b0; res_ready = 1'b0; div_done = 1'b0; div_res = 32'd0;
        @(posedge clk);
        #1;
        repeat (2) idle(1'b0);
        resetn = 1'b1;
        chk("rst_req_ready", 64'(req_ready), 64'd1);

        // div.w 100/7, tag 3, 20 divider cycles
        forced_len = 20;
        cyc(1'b1, 4'b0001, 32'd100, 32'd7, 5'd3, 1'b0, 1'b0);
        forced_len = 0;
        repeat (20) idle(1'b0);
        chk("t1_res_valid", 64'(res_valid), 64'd1);
        chk("t1_res_data", 64'(res_data), 64'd14);
        chk("t1_res_tag", 64'(res_tag), 64'd3);
        chk("t1_last_lat", 64'(last_lat), 64'd20);
        idle(1'b1);
        chk("t1_done_cnt", 64'(done_cnt), 64'd1);

        // mod.wu held against backpressure, then back-to-back div.wu
        forced_len = 5;
        cyc(1'b1, 4'b1000, 32'hFFFF_FFFF, 32'd10, 5'd7, 1'b0, 1'b0);
        forced_len = 0;
        repeat (5) idle(1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 4'b0010, 32'd50, 32'd5, 5'd9, 1'b0, 1'b0);
            chk("t2_res_data", 64'(res_data), 64'd5);
            chk("t2_req_ready", 64'(req_ready), 64'd0);
        end
        forced_len = 7;
        cyc(1'b1, 4'b0010, 32'd50, 32'd5, 5'd9, 1'b0, 1'b1);
        forced_len = 0;
        chk("t2_div_op", 64'(div_op), 64'b0010);
        chk("t2_done_cnt", 64'(done_cnt), 64'd2);
        wait_res(50);
        chk("t2_res_data2", 64'(res_data), 64'd10);
        chk("t2_last_lat", 64'(last_lat), 64'd7);
        idle(1'b1);

        // flush three cycles into BUSY -> DRAIN
        forced_len = 10;
        cyc(1'b1, 4'b0001, -32'sd20, 32'd3, 5'd1, 1'b0, 1'b0);
        forced_len = 0;
        repeat (3) idle(1'b0);
        cyc(1'b0, 4'd0, 32'd0, 32'd0, '0, 1'b1, 1'b0);
        chk("t3_busy", 64'(busy), 64'd1);
        chk("t3_div_op", 64'(div_op), 64'b0001);
        n = 0;
        while (busy && n < 20) begin
            cyc(1'b0, 4'd0, 32'd0, 32'd0, '0, 1'b1, 1'b1);
            n++;
        end
        chk("t3_drain_exit", 64'(busy), 64'd0);
        apply(1'b0, 4'd0, 32'd0, 32'd0, '0, 1'b0, 1'b0);
        #1;
        chk("t3_req_ready", 64'(req_ready), 64'd1);
        step();
        chk("t3_done_cnt", 64'(done_cnt), 64'd3);
        chk("t3_last_lat", 64'(last_lat), 64'd7);

        // flush together with div_done, then flush of a held result
        forced_len = 4;
        cyc(1'b1, 4'b0100, 32'd17, 32'd5, 5'd2, 1'b0, 1'b0);
        forced_len = 0;
        repeat (3) idle(1'b0);
        cyc(1'b0, 4'd0, 32'd0, 32'd0, '0, 1'b1, 1'b0);
        chk("t4_busy", 64'(busy), 64'd0);
        chk("t4_res_valid", 64'(res_valid), 64'd0);
        forced_len = 2;
        cyc(1'b1, 4'b0010, 32'd40, 32'd8, 5'd4, 1'b0, 1'b0);
        forced_len = 0;
        repeat (2) idle(1'b0);
        chk("t4_held", 64'(res_data), 64'd5);
        cyc(1'b0, 4'd0, 32'd0, 32'd0, '0, 1'b1, 1'b1);
        chk("t4_dropped", 64'(res_valid), 64'd0);
        chk("t4_done_cnt", 64'(done_cnt), 64'd3);

        // illegal multi-hot op
        cyc(1'b1, 4'b0110, 32'd5, 32'd5, 5'd6, 1'b0, 1'b0);
        chk("t5_res_valid", 64'(res_valid), 64'd1);
        chk("t5_res_data", 64'(res_data), 64'd0);
        chk("t5_div_op", 64'(div_op), 64'd0);
        idle(1'b1);
        chk("t5_done_cnt", 64'(done_cnt), 64'd4);

        // reset during BUSY, then div.w 9/3
        forced_len = 10;
        cyc(1'b1, 4'b0001, 32'd77, 32'd7, 5'd1, 1'b0, 1'b0);
        forced_len = 0;
        repeat (2) idle(1'b0);
        resetn = 1'b0;
        idle(1'b0);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_done_cnt", 64'(done_cnt), 64'd0);
        chk("t6_div_src1", 64'(div_src1), 64'd0);
        resetn = 1'b1;
        forced_len = 5;
        cyc(1'b1, 4'b0001, 32'd9, 32'd3, 5'd12, 1'b0, 1'b0);
        forced_len = 0;
        wait_res(30);
        chk("t6_res_data", 64'(res_data), 64'd3);

        // latency counter saturation
        forced_len = 260;
        cyc(1'b1, 4'b0010, 32'd1000, 32'd10, 5'd0, 1'b0, 1'b1);
        forced_len = 0;
        wait_res(300);
        chk("t7_last_lat", 64'(last_lat), 64'd255);
        chk("t7_res_data", 64'(res_data), 64'd100);
        idle(1'b1);

        for (int i = 0; i < 4000; i++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'(1 << $urandom_range(0, 3));
            resetn = ($urandom_range(0, 499) != 0);
            apply($urandom_range(0, 2) != 0, op, $urandom,
                  ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom,
                  TAG_W'($urandom), $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0);
            if (div_done && ph == P_RUN && $urandom_range(0, 3) == 0) flush = 1'b1;
            step();
        end
        resetn = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/div_issue_ctrl.md
# div_issue_ctrl

Issue controller between the EX stage and the shared 32-bit divider unit. It accepts one divide/modulo request at a time over a valid/ready handshake and latches the operands. It drives the divider's level-sensitive operation select until the divider reports done, then holds the result until the consumer takes it. It also handles pipeline flushes: a divide the divider IP cannot abort is drained, and its result is discarded.

## Interface
Parameters:
- TAG_W, 5, width of the destination-register tag carried alongside a request
- CNT_W, 16, width of the completed-operation counter

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- req_valid  in  1  EX stage presents a divide request
- req_ready  out  1  controller accepts the request this cycle
- req_op  in  4  one-hot op: 0001 div.w, 0010 div.wu, 0100 mod.w, 1000 mod.wu
- req_src1  in  32  dividend
- req_src2  in  32  divisor
- req_tag  in  TAG_W  destination tag, returned with the result
- flush  in  1  cancel any in-flight or held operation
- div_op  out  4  op select to the divider; nonzero only while the divider is running
- div_src1  out  32  latched dividend
- div_src2  out  32  latched divisor
- div_done  in  1  divider result valid, single-cycle
- div_res  in  32  divider result, valid with div_done
- res_valid  out  1  result is held for the consumer
- res_ready  in  1  consumer takes the result
- res_data  out  32  result
- res_tag  out  TAG_W  tag of the result
- busy  out  1  state is not IDLE
- done_cnt  out  CNT_W  results delivered, saturating
- last_lat  out  8  divider cycles of the last completed op, saturating at 255

## Operation
States are IDLE, BUSY, DONE and DRAIN, one-hot encoded.
- IDLE
  - req_ready = ~flush.
  - On accept, latch op, src1, src2 and tag.
  - If op is one-hot, go to BUSY.
  - If op is zero or multi-hot, go directly to DONE with res_data = 0; the divider is never started.
- BUSY
  - div_op = latched op.
  - div_done & ~flush: capture div_res, go to DONE.
  - flush & ~div_done: go to DRAIN.
  - flush & div_done: discard the result, go to IDLE.
- DRAIN
  - div_op stays asserted. The divider must complete, otherwise it would restart or leave stale state.
  - res_valid = 0.
  - On div_done, discard the result and go to IDLE.
  - flush is ignored in DRAIN.
- DONE
  - res_valid = 1, div_op = 0.
  - flush: drop the result, go to IDLE; done_cnt does not increment.
  - res_valid & res_ready: done_cnt++ (saturating).
  - req_ready = res_ready & ~flush.
  - Back-to-back accept goes to BUSY (or to DONE for an illegal op); otherwise go to IDLE.
- Rules that hold in every state:
  - div_op is 0 outside BUSY and DRAIN.
  - Any two divider operations are separated by at least one cycle with div_op = 0.
  - div_src1 and div_src2 are stable throughout BUSY and DRAIN.
- last_lat:
  - A counter is cleared on entry to BUSY and increments each BUSY cycle, saturating at 255.
  - last_lat is updated with this count, including the div_done cycle, on the BUSY→DONE transition only.
  - Drained ops do not update last_lat.
- div_done outside BUSY or DRAIN is ignored.

## Timing
- Reset values:
  - State IDLE.
  - div_op, div_src1, div_src2, res_valid, res_data, res_tag, busy, done_cnt and last_lat are all 0.
  - req_ready = 1 once resetn deasserts, provided flush = 0.
- Accept at edge T: busy = 1 and div_op ≠ 0 from T+1.
- div_done in cycle T+k: res_valid from T+k+1. Total request-to-result latency is k+1 cycles.
- res_data and res_tag are held stable while res_valid = 1 and res_ready = 0.
- req_ready is combinational from state, flush and res_ready. It never depends on req_valid.
- resetn asserted mid-operation: return to IDLE immediately; all outputs go to reset values.

## Test plan
- Issue div.w, src1=100, src2=7, tag=3; divider returns 14 after 20 cycles.
  -> res_valid=1 one cycle after div_done; res_data=14, res_tag=3, last_lat=20, done_cnt=1.
- mod.wu, src1=0xFFFFFFFF, src2=10, res_ready held 0 for 5 cycles.
  -> res_data=5 stays stable and req_ready=0 throughout; on res_ready, a queued div.wu is accepted the same cycle and div_op=0010 on the next cycle.
- Flush 3 cycles into BUSY.
  -> state DRAIN, div_op held until div_done, res_valid never asserts, then IDLE with req_ready=1; done_cnt and last_lat unchanged.
- Flush in the same cycle as div_done in BUSY.
  -> IDLE next cycle, no res_valid. Separately, flush with res_valid=1 drops the result and done_cnt does not increment.
- req_op=0110 (illegal).
  -> res_valid=1 at the cycle after accept, res_data=0, div_op stays 0000 throughout.
- resetn pulled low during BUSY.
  -> all outputs 0 immediately; after release, a new div.w, 9/3, returns 3.
